// File: rtl/uart_cmd_parser_pkg.sv
// Shared constants for the waveform-generator command parser: header byte,
// command codes, FSM state encoding, waveform encodings and the frame checksum.
package awg_cmd_pkg;

  localparam logic [7:0] HDR_BYTE = 8'h55;

  localparam logic [7:0] CMD_WAVE = 8'h01;
  localparam logic [7:0] CMD_FREQ = 8'h02;
  localparam logic [7:0] CMD_AMP  = 8'h03;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_GET_CMD = 3'd1,
    ST_GET_PAY = 3'd2,
    ST_GET_CHK = 3'd3,
    ST_APPLY   = 3'd4
  } cmd_state_t;

  typedef enum logic [1:0] {
    WAVE_SINE     = 2'd0,
    WAVE_SQUARE   = 2'd1,
    WAVE_TRIANGLE = 2'd2,
    WAVE_SAWTOOTH = 2'd3
  } wave_sel_t;

  // XOR of the command byte and the four payload bytes.
  function automatic logic [7:0] frame_chk(input logic [7:0] cmd, input logic [31:0] pay);
    return cmd ^ pay[31:24] ^ pay[23:16] ^ pay[15:8] ^ pay[7:0];
  endfunction

endpackage

// File: rtl/uart_cmd_parser_if.sv
// Byte stream from the UART receive stage: RX_Data is valid in the single
// cycle RX_Done_Sig is high; RX_En_Sig tells the receive stage the parser is listening.
interface uart_cmd_parser_if;
  logic       RX_Done_Sig;
  logic [7:0] RX_Data;
  logic       RX_En_Sig;

  modport master (output RX_Done_Sig, output RX_Data, input RX_En_Sig);
  modport slave  (input RX_Done_Sig, input RX_Data, output RX_En_Sig);
endinterface

// File: rtl/uart_cmd_parser_rx_timeout_counter.sv
// Inter-byte timeout counter: cleared by Clr, counts while En, and flags
// Expired in the cycle the count sits at TIMEOUT_CYCLES-1 (a clear wins).
module rx_timeout_counter #(
  parameter int unsigned TIMEOUT_CYCLES = 2500000
) (
  input  logic CLK,
  input  logic RSTn,
  input  logic Clr,
  input  logic En,
  output logic Expired
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt;

  assign Expired = En && !Clr && (cnt == LAST);

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      cnt <= '0;
    end else if (Clr || Expired) begin
      cnt <= '0;
    end else if (En) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_cmd_parser.sv
// Assembles 0x55-headed command frames into waveform-generator register writes.
// Define CMD_CHECKSUM_EN to require a trailing XOR checksum byte (7-byte frames).
module uart_cmd_parser
  import awg_cmd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 2500000,
  parameter logic [7:0]  AMP_RST        = 8'd255
) (
  input  logic                 CLK,
  input  logic                 RSTn,
  uart_cmd_parser_if.slave     rx,
  output logic [1:0]           Wave_Sel,
  output logic [31:0]          Freq_Word,
  output logic [7:0]           Amp,
  output logic                 Update_Sig,
  output logic                 Err_Sig,
  output cmd_state_t           State_Dbg
);

  cmd_state_t  state, state_nxt;
  logic [7:0]  cmd_q;
  logic [31:0] payload;
  logic [1:0]  idx;
  logic        upd_nxt, err_nxt;
  logic        wr_wave, wr_freq, wr_amp;
  logic        to_clr, to_en, to_expired;

  assign State_Dbg    = state;
  assign rx.RX_En_Sig = (state != ST_APPLY);

  // The counter only runs while a frame is partially received.
  assign to_clr = rx.RX_Done_Sig || (state == ST_IDLE);
  assign to_en  = (state == ST_GET_CMD) || (state == ST_GET_PAY) || (state == ST_GET_CHK);

  rx_timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .CLK     (CLK),
    .RSTn    (RSTn),
    .Clr     (to_clr),
    .En      (to_en),
    .Expired (to_expired)
  );

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    upd_nxt   = 1'b0;
    err_nxt   = 1'b0;
    wr_wave   = 1'b0;
    wr_freq   = 1'b0;
    wr_amp    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (rx.RX_Done_Sig && rx.RX_Data == HDR_BYTE) state_nxt = ST_GET_CMD;
      end
      ST_GET_CMD: begin
        if (rx.RX_Done_Sig) state_nxt = ST_GET_PAY;
        else if (to_expired) begin
          state_nxt = ST_IDLE;
          err_nxt   = 1'b1;
        end
      end
      ST_GET_PAY: begin
        if (rx.RX_Done_Sig) begin
          if (idx == 2'd3) begin
`ifdef CMD_CHECKSUM_EN
            state_nxt = ST_GET_CHK;
`else
            state_nxt = ST_APPLY;
`endif
          end
        end else if (to_expired) begin
          state_nxt = ST_IDLE;
          err_nxt   = 1'b1;
        end
      end
`ifdef CMD_CHECKSUM_EN
      ST_GET_CHK: begin
        if (rx.RX_Done_Sig) begin
          if (rx.RX_Data == frame_chk(cmd_q, payload)) begin
            state_nxt = ST_APPLY;
          end else begin
            state_nxt = ST_IDLE;
            err_nxt   = 1'b1;
          end
        end else if (to_expired) begin
          state_nxt = ST_IDLE;
          err_nxt   = 1'b1;
        end
      end
`endif
      ST_APPLY: begin
        state_nxt = ST_IDLE;
        upd_nxt   = 1'b1;
        case (cmd_q)
          CMD_WAVE: wr_wave = 1'b1;
          CMD_FREQ: wr_freq = 1'b1;
          CMD_AMP:  wr_amp  = 1'b1;
          default: begin
            upd_nxt = 1'b0;
            err_nxt = 1'b1;
          end
        endcase
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Payload shifts in big-endian; registers are loaded whole from it in APPLY.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      cmd_q      <= '0;
      payload    <= '0;
      idx        <= '0;
      Wave_Sel   <= WAVE_SINE;
      Freq_Word  <= '0;
      Amp        <= AMP_RST;
      Update_Sig <= 1'b0;
      Err_Sig    <= 1'b0;
    end else begin
      Update_Sig <= upd_nxt;
      Err_Sig    <= err_nxt;
      if (state == ST_GET_CMD && rx.RX_Done_Sig) begin
        cmd_q <= rx.RX_Data;
        idx   <= '0;
      end
      if (state == ST_GET_PAY && rx.RX_Done_Sig) begin
        payload <= {payload[23:0], rx.RX_Data};
        idx     <= idx + 2'd1;
      end
      if (wr_wave) Wave_Sel  <= payload[1:0];
      if (wr_freq) Freq_Word <= payload;
      if (wr_amp)  Amp       <= payload[7:0];
    end
  end

endmodule
